dot8_seq: RTL and testbench



---
 rtl/dot8_seq_if.sv | 35 +++
 rtl/dot8_seq.sv | 148 ++++++++++++++
 tb/tb_dot8_seq.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot8_seq_if.sv
// rtl/dot8_seq_if.sv - dot8_seq job, memory-read, pipeline and result signals
// master: the sequencer; slave: memories, dot8 instance and job controller.
interface dot8_seq_if #(
  parameter int OWIDTH = 32,
  parameter int VADDRW = 6,
  parameter int MADDRW = 12,
  parameter int ROWW   = 8
);
  logic              start;
  logic [ROWW-1:0]   num_rows;
  logic [VADDRW-1:0] num_chunks;
  logic [VADDRW-1:0] vec_raddr;
  logic [MADDRW-1:0] mat_raddr;
  logic              rd_en;
  logic              dot_ivalid;
  logic [OWIDTH-1:0] dot_result;
  logic              dot_ovalid;
  logic [OWIDTH-1:0] out_data;
  logic [ROWW-1:0]   out_row;
  logic              out_valid;
  logic              busy;
  logic              done;

  modport master (
    input  start, num_rows, num_chunks, dot_result, dot_ovalid,
    output vec_raddr, mat_raddr, rd_en, dot_ivalid,
    output out_data, out_row, out_valid, busy, done
  );

  modport slave (
    output start, num_rows, num_chunks, dot_result, dot_ovalid,
    input  vec_raddr, mat_raddr, rd_en, dot_ivalid,
    input  out_data, out_row, out_valid, busy, done
  );
endinterface

// File: rtl/dot8_seq.sv
// rtl/dot8_seq.sv - chunked matrix-vector sequencer around a dot8 pipeline
// Optional macro DOT8_SEQ_SAT_EN: saturating row accumulation (default wraps).
module dot8_seq #(
  parameter int OWIDTH  = 32,
  parameter int VADDRW  = 6,
  parameter int MADDRW  = 12,
  parameter int ROWW    = 8,
  parameter int DOT_LAT = 5
) (
  input logic         clk,
  input logic         rst,
  dot8_seq_if.master  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic            vld;
    logic            first;
    logic            last;
    logic            fin;
    logic [ROWW-1:0] row;
  } tag_t;

  state_t            state, state_nx;
  logic [ROWW-1:0]   nrows, row;
  logic [VADDRW-1:0] nchunks, chunk;
  logic [MADDRW-1:0] maddr;
  tag_t              tags [DOT_LAT+1];
  tag_t              tag_out;
  logic [OWIDTH-1:0] acc, acc_base, acc_nx;
  logic [OWIDTH-1:0] out_data_q;
  logic [ROWW-1:0]   out_row_q;
  logic              out_valid_q, done_q, ivalid_q;
  logic              rd_en, last_chunk, last_row, dims_ok, take;

  assign last_chunk = (chunk == nchunks - VADDRW'(1));
  assign last_row   = (row == nrows - ROWW'(1));
  assign dims_ok    = (bus.num_rows != '0) && (bus.num_chunks != '0);
  assign tag_out    = tags[DOT_LAT];
  // Results whose tag slot is empty (e.g. in flight across a reset) are dropped.
  assign take       = bus.dot_ovalid && tag_out.vld;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    case (state)
      IDLE:  if (bus.start && dims_ok) state_nx = ISSUE;
      ISSUE: begin
        rd_en = 1'b1;
        if (last_chunk && last_row) state_nx = DRAIN;
      end
      DRAIN: if (done_q) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

`ifdef DOT8_SEQ_SAT_EN
  logic [OWIDTH:0] wide;
`endif

  always_comb begin
    acc_base = tag_out.first ? '0 : acc;
`ifdef DOT8_SEQ_SAT_EN
    wide = {acc_base[OWIDTH-1], acc_base} + {bus.dot_result[OWIDTH-1], bus.dot_result};
    if (wide[OWIDTH] != wide[OWIDTH-1])
      acc_nx = wide[OWIDTH] ? {1'b1, {(OWIDTH-1){1'b0}}} : {1'b0, {(OWIDTH-1){1'b1}}};
    else
      acc_nx = wide[OWIDTH-1:0];
`else
    acc_nx = acc_base + bus.dot_result;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      nrows       <= '0;
      nchunks     <= '0;
      row         <= '0;
      chunk       <= '0;
      maddr       <= '0;
      acc         <= '0;
      out_data_q  <= '0;
      out_row_q   <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      ivalid_q    <= 1'b0;
      for (int i = 0; i <= DOT_LAT; i++) tags[i] <= '0;
    end else begin
      ivalid_q    <= rd_en;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      if (state == IDLE && bus.start) begin
        if (dims_ok) begin
          nrows   <= bus.num_rows;
          nchunks <= bus.num_chunks;
          row     <= '0;
          chunk   <= '0;
          maddr   <= '0;
        end else begin
          done_q  <= 1'b1;
        end
      end
      if (rd_en) begin
        maddr <= maddr + MADDRW'(1);
        if (last_chunk) begin
          chunk <= '0;
          row   <= row + ROWW'(1);
        end else begin
          chunk <= chunk + VADDRW'(1);
        end
      end
      // Tag travels 1 memory cycle + DOT_LAT so it lines up with dot_ovalid.
      tags[0] <= '{vld: rd_en, first: (chunk == '0), last: last_chunk,
                   fin: last_chunk && last_row, row: row};
      for (int i = 1; i <= DOT_LAT; i++) tags[i] <= tags[i-1];
      if (take) begin
        acc <= acc_nx;
        if (tag_out.last) begin
          out_data_q  <= acc_nx;
          out_row_q   <= tag_out.row;
          out_valid_q <= 1'b1;
          done_q      <= tag_out.fin;
        end
      end
    end
  end

  assign bus.rd_en      = rd_en;
  assign bus.dot_ivalid = ivalid_q;
  assign bus.vec_raddr  = chunk;
  assign bus.mat_raddr  = maddr;
  assign bus.out_data   = out_data_q;
  assign bus.out_row    = out_row_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_dot8_seq.sv
// tb/tb_dot8_seq.sv - scoreboard bench for dot8_seq with memory and dot8 models
// Runs at OWIDTH=20 so the overflow case is reachable; honours DOT8_SEQ_SAT_EN.
module tb_dot8_seq;
  localparam int OW      = 20;
  localparam int DOT_LAT = 5;
  localparam longint MAXV = (64'sd1 <<< (OW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (OW-1));
  localparam longint MASK = (64'sd1 <<< OW) - 1;

  typedef struct {
    int     row;
    longint data;
    bit     fin;
    longint cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dot8_seq_if #(.OWIDTH(OW)) bus ();
  dot8_seq #(.OWIDTH(OW), .DOT_LAT(DOT_LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic signed [7:0] vmem [64][8];
  logic signed [7:0] mmem [4096][8];
  logic signed [7:0] vq [8];
  logic signed [7:0] mq [8];
  logic   [DOT_LAT-1:0] pv = '0;
  longint pd [DOT_LAT];

  exp_t   exp_q[$];
  longint zero_q[$];
  longint cyc = 0;
  int     chk_cnt = 0, pass_cnt = 0;
  int     iss_n = 0, iss_left = 0, job_c = 1;
  bit     prev_rd = 1'b0, busy_next = 1'b0;
  longint last_data = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint fix(input longint v);
`ifdef DOT8_SEQ_SAT_EN
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
`else
    longint m = v & MASK;
    if (m > MAXV) m -= (64'sd1 <<< OW);
    return m;
`endif
  endfunction

  function automatic longint dot_mem(input int a, input int c);
    longint s = 0;
    for (int k = 0; k < 8; k++) s += longint'(mmem[a][k]) * longint'(vmem[c][k]);
    return s;
  endfunction

  // Memories (1-cycle read) and dot8 pipeline; the pipeline is deliberately not
  // reset so that stale results keep arriving after a mid-job reset.
  always @(posedge clk) begin
    longint s;
    cyc <= cyc + 1;
    if (bus.rd_en) begin
      vq <= vmem[bus.vec_raddr];
      mq <= mmem[bus.mat_raddr];
    end
    s = 0;
    for (int k = 0; k < 8; k++) s += longint'(mq[k]) * longint'(vq[k]);
    pv    <= {pv[DOT_LAT-2:0], bus.dot_ivalid};
    pd[0] <= s;
    for (int i = 1; i < DOT_LAT; i++) pd[i] <= pd[i-1];
  end
  assign bus.dot_ovalid = pv[DOT_LAT-1];
  assign bus.dot_result = OW'(pd[DOT_LAT-1]);

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (busy_next) begin
        chk("busy_low_after_done", longint'(bus.busy), 0);
        busy_next = 1'b0;
      end
      chk("ivalid_delay", longint'(bus.dot_ivalid), longint'(prev_rd));
      if (bus.rd_en) begin
        if (iss_left == 0) chk("rd_en_unexpected", 1, 0);
        else begin
          chk("mat_raddr", longint'(bus.mat_raddr), longint'(iss_n % 4096));
          chk("vec_raddr", longint'(bus.vec_raddr), longint'(iss_n % job_c));
          chk("busy_issue", longint'(bus.busy), 1);
          iss_n++;
          iss_left--;
        end
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) chk("out_valid_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          last_data = longint'($signed(bus.out_data));
          chk("out_row", longint'(bus.out_row), longint'(e.row));
          chk("out_data", last_data, e.data);
          chk("out_cycle", cyc, e.cyc);
          chk("done_align", longint'(bus.done), longint'(e.fin));
          if (e.fin) busy_next = 1'b1;
        end
      end else if (bus.done) begin
        if (zero_q.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          chk("zero_done_cycle", cyc, zero_q.pop_front());
          chk("zero_busy", longint'(bus.busy), 0);
        end
      end
    end
    prev_rd = bus.rd_en;
  end

  task automatic launch(input int r, input int c);
    longint s, acc;
    exp_t   e;
    @(negedge clk);
    s = cyc + 1;
    bus.start      = 1'b1;
    bus.num_rows   = 8'(r);
    bus.num_chunks = 6'(c);
    if (r == 0 || c == 0) zero_q.push_back(s);
    else begin
      iss_n = 0;
      iss_left = r * c;
      job_c = c;
      for (int i = 0; i < r; i++) begin
        acc = 0;
        for (int j = 0; j < c; j++) begin
          if (j == 0) acc = fix(dot_mem((i * c + j) % 4096, j));
          else        acc = fix(acc + dot_mem((i * c + j) % 4096, j));
        end
        e.row = i; e.data = acc; e.fin = (i == r - 1);
        e.cyc = s + longint'((i + 1) * c) + 1 + DOT_LAT;
        exp_q.push_back(e);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && zero_q.size() == 0 && iss_left == 0 && !bus.busy && !busy_next) begin
        ok = 1'b1;
        break;
      end
    end
    chk("job_complete", longint'(ok), 1);
  endtask

  task automatic check_reset_vals();
    chk("rst_rd_en",     longint'(bus.rd_en), 0);
    chk("rst_ivalid",    longint'(bus.dot_ivalid), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_busy",      longint'(bus.busy), 0);
    chk("rst_done",      longint'(bus.done), 0);
    chk("rst_out_data",  longint'(bus.out_data), 0);
    chk("rst_out_row",   longint'(bus.out_row), 0);
    chk("rst_vec_raddr", longint'(bus.vec_raddr), 0);
    chk("rst_mat_raddr", longint'(bus.mat_raddr), 0);
  endtask

  initial begin
    longint ovf_exp;
    bus.start = 1'b0;
    bus.num_rows = '0;
    bus.num_chunks = '0;
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 8; k++) vmem[i][k] = 8'($urandom);
    for (int i = 0; i < 4096; i++)
      for (int k = 0; k < 8; k++) mmem[i][k] = 8'($urandom);
    repeat (3) @(negedge clk);
    check_reset_vals();
    #1 rst = 1'b0;

    // basic job: expects 48 then -24
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 3; c++) begin
        vmem[c][k] = 8'sd1;
        mmem[c][k] = 8'sd2;
        mmem[3 + c][k] = -8'sd1;
      end
    end
    launch(2, 3);
    wait_idle(40);

    // single chunk per row: 0, 24, 48, 72 on consecutive cycles
    for (int k = 0; k < 8; k++) begin
      vmem[0][k] = 8'sd3;
      for (int r = 0; r < 4; r++) mmem[r][k] = 8'(r);
    end
    launch(4, 1);
    wait_idle(40);

    launch(0, 5);
    wait_idle(20);
    launch(3, 0);
    wait_idle(20);

    // overflow: 4 chunks of 131072 at 20 bits
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < 4; c++) begin
        vmem[c][k] = -8'sd128;
        mmem[c][k] = -8'sd128;
      end
    end
    launch(1, 4);
    wait_idle(40);
`ifdef DOT8_SEQ_SAT_EN
    ovf_exp = 524287;
`else
    ovf_exp = -524288;
`endif
    chk("overflow_result", last_data, ovf_exp);

    // start while busy is ignored
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < 8; k++) vmem[i][k] = 8'($urandom);
    launch(2, 3);
    @(negedge clk);
    bus.start = 1'b1; bus.num_rows = 8'd1; bus.num_chunks = 6'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(40);

    // reset mid-job: rst sampled at the end of cycle 6
    launch(3, 4);
    repeat (5) @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    zero_q.delete();
    iss_left = 0;
    busy_next = 1'b0;
    @(negedge clk);
    check_reset_vals();
    #1 rst = 1'b0;
    repeat (25) @(negedge clk);
    chk("post_reset_quiet_busy", longint'(bus.busy), 0);
    launch(3, 4);
    wait_idle(60);

    // random jobs
    for (int t = 0; t < 8; t++) begin
      launch(int'($urandom_range(1, 5)), int'($urandom_range(1, 6)));
      wait_idle(80);
    end

    // long job wrapping the matrix address
    launch(70, 63);
    wait_idle(70 * 63 + 60);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
